// File: rtl/unified_mem_responder_pkg.sv
// Shared definitions for the unified instruction/data memory responder.
package unified_mem_responder_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requesting port identifiers
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/unified_mem_responder_mem_lane_align.sv
// Byte-lane steering for little-endian sub-word loads and stores.
module mem_lane_align
    import unified_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic [31:0] store_word,
    output logic [3:0]  byte_en,
    output logic        misalign
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select addressed byte/halfword, extend loads, replicate store data, build byte enables
    always_comb begin
        misalign    = 1'b0;
        lane_byte   = word_in[7:0];
        lane_half   = addr[1] ? word_in[31:16] : word_in[15:0];
        load_result = '0;
        store_word  = wdata;
        byte_en     = '0;

        case (addr)
            2'd0:    lane_byte = word_in[7:0];
            2'd1:    lane_byte = word_in[15:8];
            2'd2:    lane_byte = word_in[23:16];
            default: lane_byte = word_in[31:24];
        endcase

        case (funct3)
            F3_B, F3_BU: misalign = 1'b0;
            F3_H, F3_HU: misalign = addr[0];
            F3_W:        misalign = (addr != 2'd0);
            default:     misalign = 1'b1;
        endcase

        case (funct3)
            F3_B:    load_result = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_result = {24'd0, lane_byte};
            F3_H:    load_result = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_result = {16'd0, lane_half};
            F3_W:    load_result = word_in;
            default: load_result = '0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                store_word = {4{wdata[7:0]}};
                case (addr)
                    2'd0:    byte_en = 4'b0001;
                    2'd1:    byte_en = 4'b0010;
                    2'd2:    byte_en = 4'b0100;
                    default: byte_en = 4'b1000;
                endcase
            end
            2'b01: begin
                store_word = {2{wdata[15:0]}};
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                store_word = wdata;
                byte_en    = 4'b1111;
            end
            default: begin
                store_word = wdata;
                byte_en    = 4'b0000;
            end
        endcase

        if (misalign) begin
            load_result = '0;
            byte_en     = '0;
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Shared IF/MEM memory responder: arbitration, fixed-latency access, ack and stall.
module unified_mem_responder
    import unified_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              stall
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    gnt_t              gnt_q, gnt_d;
    gnt_t              last_q, last_d;
    logic              take;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              mis_q;

    logic              access;
    logic              mem_we;
    logic [31:0]       word_rd;
    logic [31:0]       load_result;
    logic [31:0]       store_word;
    logic [3:0]        byte_en;
    logic              misalign;

    assign word_rd = mem[addr_q[ADDR_W-1:2]];
    assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mem_we  = access && (gnt_q == GNT_D) && we_q && !misalign && !rst;

    assign if_ack     = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_ack      = (state_q == RESP) && (gnt_q == GNT_D);
    assign d_misalign = d_ack & mis_q;
    assign stall      = (if_req & ~if_ack) | (d_req & ~d_ack);

    mem_lane_align u_align (
        .funct3      (f3_q),
        .addr        (addr_q[1:0]),
        .word_in     (word_rd),
        .wdata       (wdata_q),
        .load_result (load_result),
        .store_word  (store_word),
        .byte_en     (byte_en),
        .misalign    (misalign)
    );

    // Next-state: round-robin tie arbitration in IDLE, latency countdown in BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    if (if_req && d_req)
                        gnt_d = (last_q == GNT_I) ? GNT_D : GNT_I;
                    else if (d_req)
                        gnt_d = GNT_D;
                    else
                        gnt_d = GNT_I;
                    take    = 1'b1;
                    last_d  = gnt_d;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                else
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= GNT_I;
            last_q   <= GNT_I;
            we_q     <= 1'b0;
            f3_q     <= F3_W;
            addr_q   <= '0;
            wdata_q  <= '0;
            mis_q    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            if (take) begin
                if (gnt_d == GNT_D) begin
                    we_q    <= d_we;
                    f3_q    <= d_funct3;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    we_q    <= 1'b0;
                    f3_q    <= F3_W;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (access) begin
                if (gnt_q == GNT_I) begin
                    if_rdata <= word_rd;
                end else begin
                    mis_q   <= misalign;
                    d_rdata <= (we_q || misalign) ? 32'd0 : load_result;
                end
            end
        end
    end

    // Byte-enabled storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed self-checking bench for unified_mem_responder (LATENCY=1 and LATENCY=3 instances).
module tb_unified_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    // LATENCY=1 instance
    logic        if_req, if_ack, d_req, d_we, d_ack, d_misalign, stall;
    logic [7:0]  if_addr, d_addr;
    logic [2:0]  d_funct3;
    logic [31:0] if_rdata, d_wdata, d_rdata;

    // LATENCY=3 instance
    logic        i3_req, i3_ack, d3_req, d3_we, d3_ack, d3_misalign, stall3;
    logic [7:0]  i3_addr, d3_addr;
    logic [2:0]  d3_funct3;
    logic [31:0] i3_rdata, d3_wdata, d3_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unified_mem_responder #(.ADDR_W(8), .DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .d_misalign(d_misalign), .stall(stall)
    );

    unified_mem_responder #(.ADDR_W(8), .DEPTH_WORDS(64), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(i3_req), .if_addr(i3_addr), .if_ack(i3_ack), .if_rdata(i3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_funct3(d3_funct3), .d_addr(d3_addr),
        .d_wdata(d3_wdata), .d_ack(d3_ack), .d_rdata(d3_rdata),
        .d_misalign(d3_misalign), .stall(stall3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 in an IDLE cycle; returns at posedge+1 of the cycle after the ack
    task automatic d_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic mis, output int lat);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        lat = 0;
        #1;
        while (d_ack !== 1'b1 && lat < 50) begin
            @(posedge clk); #2; lat++;
        end
        rd = d_rdata; mis = d_misalign;
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic d3_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic mis, output int lat);
        d3_req = 1'b1; d3_we = we; d3_funct3 = f3; d3_addr = a; d3_wdata = wd;
        lat = 0;
        #1;
        while (d3_ack !== 1'b1 && lat < 50) begin
            @(posedge clk); #2; lat++;
        end
        rd = d3_rdata; mis = d3_misalign;
        d3_req = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, irdv, drdv;
    logic        mis;
    int          lat, cyc, dack_c, iack_c;

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
        i3_req = 0; i3_addr = '0; d3_req = 0; d3_we = 0; d3_funct3 = '0; d3_addr = '0; d3_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_d_mis", {31'd0, d_misalign}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload words 0 and 1
        d_op(1'b1, 3'b010, 8'h00, 32'h8899AABB, rd, mis, lat);
        check("sw0_lat", lat, 32'd2);
        check("sw0_rdata", rd, 32'd0);
        check("sw0_mis", {31'd0, mis}, 32'd0);
        d_op(1'b1, 3'b010, 8'h04, 32'h11223344, rd, mis, lat);

        // Fetch word 0 with per-cycle stall observation
        if_req = 1'b1; if_addr = 8'h00;
        #1;
        check("f_c0_stall", {31'd0, stall}, 32'd1);
        check("f_c0_ack", {31'd0, if_ack}, 32'd0);
        @(posedge clk); #2;
        check("f_c1_stall", {31'd0, stall}, 32'd1);
        check("f_c1_ack", {31'd0, if_ack}, 32'd0);
        @(posedge clk); #2;
        check("f_c2_ack", {31'd0, if_ack}, 32'd1);
        check("f_c2_rdata", if_rdata, 32'h8899AABB);
        check("f_c2_stall", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        @(posedge clk); #1;

        // Byte store then signed/unsigned byte loads
        d_op(1'b1, 3'b000, 8'h05, 32'h000000EE, rd, mis, lat);
        check("sb_mis", {31'd0, mis}, 32'd0);
        d_op(1'b0, 3'b000, 8'h05, 32'h0, rd, mis, lat);
        check("lb_05", rd, 32'hFFFFFFEE);
        check("lb_lat", lat, 32'd2);
        d_op(1'b0, 3'b100, 8'h05, 32'h0, rd, mis, lat);
        check("lbu_05", rd, 32'h000000EE);
        d_op(1'b0, 3'b010, 8'h04, 32'h0, rd, mis, lat);
        check("lw_04", rd, 32'h1122EE44);
        d_op(1'b0, 3'b001, 8'h06, 32'h0, rd, mis, lat);
        check("lh_06", rd, 32'h00001122);
        d_op(1'b0, 3'b101, 8'h04, 32'h0, rd, mis, lat);
        check("lhu_04", rd, 32'h0000EE44);

        // Error cases
        d_op(1'b0, 3'b010, 8'h06, 32'h0, rd, mis, lat);
        check("lw06_mis", {31'd0, mis}, 32'd1);
        check("lw06_rdata", rd, 32'd0);
        check("lw06_lat", lat, 32'd2);
        d_op(1'b1, 3'b010, 8'h02, 32'hFFFFFFFF, rd, mis, lat);
        check("sw02_mis", {31'd0, mis}, 32'd1);
        d_op(1'b0, 3'b010, 8'h00, 32'h0, rd, mis, lat);
        check("w0_unchanged", rd, 32'h8899AABB);
        check("lw00_mis", {31'd0, mis}, 32'd0);
        d_op(1'b0, 3'b011, 8'h00, 32'h0, rd, mis, lat);
        check("f3_011_mis", {31'd0, mis}, 32'd1);
        check("f3_011_rdata", rd, 32'd0);
        d_op(1'b0, 3'b001, 8'h05, 32'h0, rd, mis, lat);
        check("lh05_mis", {31'd0, mis}, 32'd1);

        // Tie right after reset: D first at cycle 2, fetch of same word at cycle 5 sees store
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h0C; d_wdata = 32'hCAFEF00D;
        if_req = 1'b1; if_addr = 8'h0C;
        cyc = 0; dack_c = -1; iack_c = -1; irdv = '0; drdv = '0;
        #1;
        while ((dack_c < 0 || iack_c < 0) && cyc < 30) begin
            if (d_ack === 1'b1)  begin dack_c = cyc; drdv = d_rdata; d_req = 1'b0; end
            if (if_ack === 1'b1) begin iack_c = cyc; irdv = if_rdata; if_req = 1'b0; end
            @(posedge clk); #2; cyc++;
        end
        d_req = 1'b0; if_req = 1'b0;
        check("tie1_d_cycle", dack_c, 32'd2);
        check("tie1_i_cycle", iack_c, 32'd5);
        check("tie1_st_rdata", drdv, 32'd0);
        check("tie1_fetch_new", irdv, 32'hCAFEF00D);
        @(posedge clk); #1;

        // D-only access leaves last_grant=D, so the next tie goes to I
        d_op(1'b0, 3'b010, 8'h04, 32'h0, rd, mis, lat);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h00; d_wdata = '0;
        if_req = 1'b1; if_addr = 8'h07;
        cyc = 0; dack_c = -1; iack_c = -1;
        #1;
        while ((dack_c < 0 || iack_c < 0) && cyc < 30) begin
            if (d_ack === 1'b1)  begin dack_c = cyc; drdv = d_rdata; d_req = 1'b0; end
            if (if_ack === 1'b1) begin iack_c = cyc; irdv = if_rdata; if_req = 1'b0; end
            @(posedge clk); #2; cyc++;
        end
        d_req = 1'b0; if_req = 1'b0;
        check("tie2_i_cycle", iack_c, 32'd2);
        check("tie2_d_cycle", dack_c, 32'd5);
        check("tie2_fetch_w1", irdv, 32'h1122EE44);
        check("tie2_load_w0", drdv, 32'h8899AABB);
        @(posedge clk); #1;

        // Reset during the access cycle of a store drops it
        d_op(1'b1, 3'b010, 8'h10, 32'h01020304, rd, mis, lat);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #2;
        check("rmid_d_ack", {31'd0, d_ack}, 32'd0);
        check("rmid_if_ack", {31'd0, if_ack}, 32'd0);
        check("rmid_d_mis", {31'd0, d_misalign}, 32'd0);
        check("rmid_d_rdata", d_rdata, 32'd0);
        check("rmid_if_rdata", if_rdata, 32'd0);
        check("rmid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        d_op(1'b0, 3'b010, 8'h10, 32'h0, rd, mis, lat);
        check("rmid_w4_kept", rd, 32'h01020304);

        // LATENCY=3 instance: halfword store and loads, ack 4 cycles after acceptance
        d3_op(1'b1, 3'b001, 8'h0A, 32'h0000BEEF, rd, mis, lat);
        check("l3_sh_lat", lat, 32'd4);
        check("l3_sh_mis", {31'd0, mis}, 32'd0);
        d3_op(1'b0, 3'b101, 8'h0A, 32'h0, rd, mis, lat);
        check("l3_lhu", rd, 32'h0000BEEF);
        check("l3_lhu_lat", lat, 32'd4);
        d3_op(1'b0, 3'b001, 8'h0A, 32'h0, rd, mis, lat);
        check("l3_lh", rd, 32'hFFFFBEEF);
        check("l3_lh_lat", lat, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
